pattern_streamer: RTL

PATTERN_STREAMER -- requirements
Module: pattern_streamer

---
 rtl/pattern_streamer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pattern_streamer.sv
// pattern_streamer: serialises a captured pattern MSB first, repeating it
// repeat_count+1 times with gap_cycles idle cycles between repetitions.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; all outputs low
// SHIFT  | presenting one pattern bit per cycle (stream_valid=1)
// GAP    | idle cycles between repetitions (stream_valid=0)
// DONE   | single completion cycle (done=1), then back to IDLE
module pattern_streamer #(
    parameter int PATTERN_WIDTH = 8,
    parameter int REPEAT_WIDTH  = 4,
    parameter int GAP_WIDTH     = 4,
    localparam int LEN_WIDTH    = $clog2(PATTERN_WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PATTERN_WIDTH-1:0] pattern_in,
    input  logic [LEN_WIDTH-1:0]     pattern_len,
    input  logic [REPEAT_WIDTH-1:0]  repeat_count,
    input  logic [GAP_WIDTH-1:0]     gap_cycles,
    output logic                     stream_out,
    output logic                     stream_valid,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(PATTERN_WIDTH);

    state_t                    state_q, state_d;
    logic [PATTERN_WIDTH-1:0]  pat_q, pat_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [REPEAT_WIDTH-1:0]   rep_q, rep_d;
    logic [GAP_WIDTH-1:0]      gap_q, gap_d;
    logic [LEN_WIDTH-1:0]      bit_q, bit_d;
    logic [GAP_WIDTH-1:0]      gap_cnt_q, gap_cnt_d;
    logic                      out_d, valid_d, busy_d, done_d;

    logic [LEN_WIDTH-1:0]      len_in_c;
    logic [PATTERN_WIDTH-1:0]  in_first_sh;
    logic [PATTERN_WIDTH-1:0]  q_first_sh;
    logic [PATTERN_WIDTH-1:0]  q_next_sh;

    // Clamp the requested length and line up the bit that will be sent next;
    // shifting avoids indexing with a wider-than-needed index.
    assign len_in_c    = (pattern_len > MAX_LEN) ? MAX_LEN : pattern_len;
    assign in_first_sh = pattern_in >> (len_in_c - LEN_WIDTH'(1));
    assign q_first_sh  = pat_q >> (len_q - LEN_WIDTH'(1));
    assign q_next_sh   = pat_q >> (bit_q - LEN_WIDTH'(1));

    // Next-state and next-output logic; outputs default to the idle values.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d  = pattern_in;
                    len_d  = len_in_c;
                    rep_d  = repeat_count;
                    gap_d  = gap_cycles;
                    busy_d = 1'b1;
                    if (len_in_c == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        bit_d   = len_in_c - LEN_WIDTH'(1);
                        out_d   = in_first_sh[0];
                        valid_d = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_q != '0) begin
                    bit_d   = bit_q - LEN_WIDTH'(1);
                    out_d   = q_next_sh[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d  = rep_q - REPEAT_WIDTH'(1);
                    busy_d = 1'b1;
                    if (gap_q != '0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        bit_d   = len_q - LEN_WIDTH'(1);
                        out_d   = q_first_sh[0];
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = ST_SHIFT;
                    bit_d   = len_q - LEN_WIDTH'(1);
                    out_d   = q_first_sh[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                    busy_d    = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, captured request and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            rep_q        <= '0;
            gap_q        <= '0;
            bit_q        <= '0;
            gap_cnt_q    <= '0;
            stream_out   <= 1'b0;
            stream_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            len_q        <= len_d;
            rep_q        <= rep_d;
            gap_q        <= gap_d;
            bit_q        <= bit_d;
            gap_cnt_q    <= gap_cnt_d;
            stream_out   <= out_d;
            stream_valid <= valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule
